// File: rtl/sd_block_tx_pkg.sv
// Shared types and constants for the SD single-block write data-phase engine.
package sd_block_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        TOKEN,
        DATA,
        CRC,
        RESP,
        BUSY,
        FIN
    } sd_state_e;

    localparam logic [7:0] TOKEN_START = 8'hFE;

    localparam logic [2:0] RESP_OK   = 3'b010;
    localparam logic [2:0] RESP_CRC  = 3'b101;
    localparam logic [2:0] RESP_WERR = 3'b110;
    localparam logic [2:0] RESP_TMO  = 3'b111;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (poly 0x1021, init 0x0000), MSB-first data.
module sd_crc16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic fb;

    assign fb = crc[15] ^ bit_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_block_tx.sv
// SPI mode-0 data phase of an SD CMD24 block write: gap, start token, sector, CRC, response, busy.
// Define SD_CRC16_EN to send a real CRC16 over the data; otherwise 0xFFFF is sent.
module sd_block_tx
    import sd_block_tx_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int BLK_BYTES    = 512,
    parameter int RESP_TIMEOUT = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] status,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       SCLK,
    output logic       DI,
    output logic       CS,
    input  logic       DO
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [9:0]  BYTE_LAST = 10'(BLK_BYTES - 1);
    localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

    sd_state_e   state;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [9:0]  byte_idx;
    logic        crc_lo;
    logic [15:0] tmo_cnt;
    logic [7:0]  nxt_byte;
    logic [15:0] crc_val;
    logic        half_end;
    logic        start_ok;
    logic        token_hit;

    assign half_end  = (div_cnt == DIV_LAST);
    assign start_ok  = (state == IDLE) && start && !done;
    assign token_hit = !rx_sh[4] && rx_sh[0];

`ifdef SD_CRC16_EN
    logic [15:0] crc;

    // Each data bit is folded in at its SCLK rising edge, while it is on DI.
    sd_crc16 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (start_ok),
        .en     ((state == DATA) && half_end && !SCLK),
        .bit_in (DI),
        .crc    (crc)
    );

    assign crc_val = crc;
`else
    assign crc_val = 16'hFFFF;
`endif

    // Byte loaded at the end of the current byte, chosen by the state being left.
    always_comb begin
        nxt_byte = 8'hFF;
        case (state)
            GAP:     nxt_byte = TOKEN_START;
            TOKEN:   nxt_byte = rd_data;
            DATA:    nxt_byte = (byte_idx == BYTE_LAST) ? crc_val[15:8] : rd_data;
            CRC:     nxt_byte = crc_lo ? 8'hFF : crc_val[7:0];
            default: nxt_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            status   <= 3'b000;
            rd_addr  <= 9'd0;
            SCLK     <= 1'b0;
            DI       <= 1'b1;
            CS       <= 1'b1;
            div_cnt  <= 16'd0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 7'h7F;
            rx_sh    <= 8'hFF;
            byte_idx <= 10'd0;
            crc_lo   <= 1'b0;
            tmo_cnt  <= 16'd0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= 16'd0;
                bit_cnt <= 3'd0;
                if (start_ok) begin
                    busy    <= 1'b1;
                    CS      <= 1'b0;
                    rd_addr <= 9'd0;
                    status  <= 3'b000;
                    err     <= 1'b0;
                    tx_sh   <= 7'h7F;
                    DI      <= 1'b1;
                    state   <= GAP;
                end
            end else if (!half_end) begin
                div_cnt <= div_cnt + 16'd1;
            end else begin
                div_cnt <= 16'd0;
                if (!SCLK) begin
                    SCLK  <= 1'b1;
                    rx_sh <= {rx_sh[6:0], DO};
                end else begin
                    SCLK <= 1'b0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        DI      <= tx_sh[6];
                        tx_sh   <= {tx_sh[5:0], 1'b1};
                    end else begin
                        // Byte boundary: next byte goes out on the very next low half.
                        bit_cnt <= 3'd0;
                        DI      <= nxt_byte[7];
                        tx_sh   <= nxt_byte[6:0];
                        case (state)
                            GAP: state <= TOKEN;
                            TOKEN: begin
                                state    <= DATA;
                                byte_idx <= 10'd0;
                                rd_addr  <= rd_addr + 9'd1;
                            end
                            DATA: begin
                                if (byte_idx == BYTE_LAST) begin
                                    state  <= CRC;
                                    crc_lo <= 1'b0;
                                end else begin
                                    byte_idx <= byte_idx + 10'd1;
                                    rd_addr  <= rd_addr + 9'd1;
                                end
                            end
                            CRC: begin
                                if (!crc_lo) begin
                                    crc_lo <= 1'b1;
                                end else begin
                                    state   <= RESP;
                                    tmo_cnt <= 16'd0;
                                end
                            end
                            RESP: begin
                                if (token_hit) begin
                                    status  <= rx_sh[3:1];
                                    state   <= BUSY;
                                    tmo_cnt <= 16'd0;
                                end else if (tmo_cnt == RESP_LAST) begin
                                    status <= RESP_TMO;
                                    state  <= FIN;
                                    CS     <= 1'b1;
                                end else begin
                                    tmo_cnt <= tmo_cnt + 16'd1;
                                end
                            end
                            BUSY: begin
                                if (rx_sh == 8'hFF) begin
                                    state <= FIN;
                                    CS    <= 1'b1;
                                end else if (tmo_cnt == BUSY_LAST) begin
                                    status <= RESP_TMO;
                                    state  <= FIN;
                                    CS     <= 1'b1;
                                end else begin
                                    tmo_cnt <= tmo_cnt + 16'd1;
                                end
                            end
                            FIN: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                err   <= (status != RESP_OK);
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_block_tx.sv
// Bench for sd_block_tx: a CLK_DIV=4 and a CLK_DIV=1 instance share a sector memory and an SD card model.
`timescale 1ns/1ps
module tb_sd_block_tx;

    localparam int PRE_RESP = 516;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] start_v = 2'b00;
    logic [1:0] busy_v;

    logic [7:0] mem [512];
    logic [7:0] do_arr [8];
    int         do_len = 0;

    logic [7:0] exp_q[$];
    logic [3:0] exp_done_q[$];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : slv
        localparam int DIV = (g == 0) ? 4 : 1;

        logic       busy, done, err, sclk, di, cs, do_bit;
        logic [2:0] status;
        logic [8:0] rd_addr;
        logic [7:0] rd_data = 8'h00;
        logic [7:0] rx_b = 8'h00;
        logic       first_rise = 1'b1;
        int bit_cnt = 0, byte_cnt = 0, cs_falls = 0, fin_clks = 0;
        int done_cnt = 0, gap_err = 0, cyc = 0, last_rise = 0;

        sd_block_tx #(.CLK_DIV(DIV)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .start   (start_v[g]),
            .busy    (busy),
            .done    (done),
            .err     (err),
            .status  (status),
            .rd_addr (rd_addr),
            .rd_data (rd_data),
            .SCLK    (sclk),
            .DI      (di),
            .CS      (cs),
            .DO      (do_bit)
        );

        assign busy_v[g] = busy;

        always @(posedge clk) begin
            cyc++;
            rd_data <= mem[rd_addr];
        end

        // Card model: 0xFF until the response window, then the scripted bytes.
        always_comb begin
            int idx;
            logic [7:0] b;
            idx = byte_cnt - PRE_RESP;
            b = 8'hFF;
            if (idx >= 0 && idx < do_len) b = do_arr[idx[2:0]];
            do_bit = cs ? 1'b1 : b[3'(7 - bit_cnt)];
        end

        always @(negedge cs) begin
            bit_cnt = 0;
            byte_cnt = 0;
            fin_clks = 0;
            first_rise = 1'b1;
            cs_falls++;
        end

        always @(posedge sclk) begin
            if (cs) begin
                fin_clks++;
            end else begin
                if (!first_rise && byte_cnt < PRE_RESP && (cyc - last_rise) != 2 * DIV) gap_err++;
                first_rise = 1'b0;
                last_rise = cyc;
                rx_b = {rx_b[6:0], di};
                if (bit_cnt == 7) begin
                    bit_cnt = 0;
                    byte_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mosi_extra[%0d]: got 0x%0h, expected no byte", g, rx_b);
                    end else begin
                        check("mosi_byte", 32'(rx_b), 32'(exp_q.pop_front()));
                    end
                end else begin
                    bit_cnt++;
                end
            end
        end

        always @(negedge clk) begin
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_extra[%0d]: got done=1, expected no done", g);
                end else begin
                    check("done_err_status", 32'({err, status}), 32'(exp_done_q.pop_front()));
                end
                check("cs_high_at_done", 32'(cs), 32'd1);
                check("fin_clocks", 32'(fin_clks), 32'd8);
                check("inter_byte_gaps", 32'(gap_err), 32'd0);
                check("mosi_drained", 32'(exp_q.size()), 32'd0);
                gap_err = 0;
            end
        end
    end

    function automatic logic [15:0] exp_crc();
`ifdef SD_CRC16_EN
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ mem[i][b];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
`else
        return 16'hFFFF;
`endif
    endfunction

    task automatic load_mem(input bit all_ff);
        for (int i = 0; i < 512; i++) mem[i] = all_ff ? 8'hFF : 8'(i);
    endtask

    task automatic push_block(input int n_post, input logic [3:0] dn);
        logic [15:0] c;
        c = exp_crc();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_q.push_back(mem[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        for (int i = 0; i < n_post; i++) exp_q.push_back(8'hFF);
        exp_done_q.push_back(dn);
    endtask

    task automatic pulse_start(input int inst);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
    endtask

    // restart=1 raises start in the cycle done is high; it must be ignored.
    task automatic wait_idle(input int inst, input int budget, input bit restart);
        int n;
        n = 0;
        while (busy_v[inst] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[inst]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle[%0d]: still busy after %0d cycles, expected idle", inst, budget);
        end else if (restart) begin
            start_v[inst] = 1'b1;
            @(negedge clk);
            start_v[inst] = 1'b0;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic script_ok();
        do_arr[0] = 8'hE5;
        do_arr[1] = 8'h00;
        do_arr[2] = 8'h00;
        do_arr[3] = 8'h00;
        do_arr[4] = 8'hFF;
        do_len = 5;
    endtask

    initial begin
        int falls0;
        int dc0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(slv[0].busy), 32'd0);
        check("rst_done", 32'(slv[0].done), 32'd0);
        check("rst_err", 32'(slv[0].err), 32'd0);
        check("rst_status", 32'(slv[0].status), 32'd0);
        check("rst_rd_addr", 32'(slv[0].rd_addr), 32'd0);
        check("rst_sclk", 32'(slv[0].sclk), 32'd0);
        check("rst_di", 32'(slv[0].di), 32'd1);
        check("rst_cs", 32'(slv[0].cs), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Incrementing sector, token 0xE5, three busy bytes, CLK_DIV=4.
        load_mem(1'b0);
        script_ok();
        push_block(5, 4'b0010);
        pulse_start(0);
        check("busy_after_start", 32'(slv[0].busy), 32'd1);
        check("cs_low_after_start", 32'(slv[0].cs), 32'd0);
        wait_idle(0, 40000, 1'b0);
        check("status_holds", 32'(slv[0].status), 32'b010);
        check("dout_bytes_sent", 32'(slv[0].byte_cnt), 32'd521);

        // Same stimulus at CLK_DIV=1.
        push_block(5, 4'b0010);
        pulse_start(1);
        wait_idle(1, 12000, 1'b0);
        check("fast_bytes_sent", 32'(slv[1].byte_cnt), 32'd521);

        // All-0xFF sector, rejected with 0x0B, with a stray start mid-DATA.
        load_mem(1'b1);
        do_arr[0] = 8'h0B;
        do_len = 1;
        push_block(2, 4'b1101);
        falls0 = slv[1].cs_falls;
        pulse_start(1);
        n = 0;
        while (slv[1].byte_cnt < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_data", 32'(slv[1].byte_cnt >= 100), 32'd1);
        pulse_start(1);
        wait_idle(1, 12000, 1'b0);
        check("one_block_only", 32'(slv[1].cs_falls - falls0), 32'd1);
        check("crc_err_status", 32'(slv[1].status), 32'b101);

        // DO stuck high: response timeout; start coinciding with done is dropped.
        load_mem(1'b0);
        do_len = 0;
        push_block(8, 4'b1111);
        falls0 = slv[1].cs_falls;
        pulse_start(1);
        wait_idle(1, 12000, 1'b1);
        check("tmo_busy_low", 32'(busy_v[1]), 32'd0);
        check("start_at_done_ignored", 32'(slv[1].cs_falls - falls0), 32'd1);

        // Reset mid-DATA on the CLK_DIV=4 instance.
        script_ok();
        push_block(5, 4'b0010);
        pulse_start(0);
        n = 0;
        while (slv[0].byte_cnt < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_data", 32'(slv[0].byte_cnt >= 6), 32'd1);
        dc0 = slv[0].done_cnt;
        reset = 1'b0;
        #1;
        check("abort_cs", 32'(slv[0].cs), 32'd1);
        check("abort_di", 32'(slv[0].di), 32'd1);
        check("abort_sclk", 32'(slv[0].sclk), 32'd0);
        check("abort_busy", 32'(slv[0].busy), 32'd0);
        exp_q.delete();
        exp_done_q.delete();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_done", 32'(slv[0].done_cnt - dc0), 32'd0);
        check("abort_idle", 32'(slv[0].busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_block_tx.md
Name: sd_block_tx

Overview:
- SPI data-phase engine for an SD single-block write (CMD24 data phase). Sits directly downstream of the 512-byte sector collector.
- On `start`, it reads the 512-byte sector through a synchronous read port and drives the start token, data, CRC16 and response/busy handshake on the SD SPI pins.
- Reports card status and completion to the collector, which then re-enables its byte intake.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (≥1); one SPI bit = 2*CLK_DIV clk cycles.
- BLK_BYTES, 512: data bytes per block.
- RESP_TIMEOUT, 8: max bytes clocked while waiting for the data-response token.
- BUSY_TIMEOUT, 65535: max bytes clocked while the card holds DO low (busy).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send a block; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion, success or error.
- err  out  1  valid with done; 1 = rejected token or timeout.
- status  out  3  response token bits [3:1]; 3'b111 = timeout.
- rd_addr  out  9  sector buffer read address.
- rd_data  in  8  sector buffer data, valid one clk after rd_addr.
- SCLK  out  1  SPI clock, idle low (mode 0).
- DI  out  1  SPI MOSI, idle high.
- CS  out  1  SPI chip select, active low.
- DO  in  1  SPI MISO.

Behaviour:
- Reset values: SCLK=0, DI=1, CS=1, busy=0, done=0, err=0, status=0, rd_addr=0, FSM=IDLE. Reset asserted mid-operation aborts at once: CS high, SCLK low, no done pulse.
- Byte engine:
  - Shifts MSB first.
  - DI updates while SCLK is low, one half-period before the rising edge.
  - DO is sampled on the SCLK rising edge.
  - Falling edge ends each bit.
  - Every byte sent also captures one received byte.
- FSM:
  - IDLE: when `start` arrives, set busy=1, CS=0, rd_addr=0, go to GAP.
  - GAP: send one 0xFF byte, then go to TOKEN.
  - TOKEN: send 0xFE, then go to DATA.
  - DATA:
    - Send bytes 0..BLK_BYTES-1.
    - Byte n+1 is prefetched during byte n by advancing rd_addr at byte n's start, so no gap cycles occur between bytes.
    - After the last byte, go to CRC.
  - CRC: send 2 bytes, high byte first, then go to RESP.
  - RESP:
    - Send 0xFF bytes.
    - A received byte matching xxx0sss1 is the token: status=sss, then go to BUSY.
    - After RESP_TIMEOUT bytes with no match: status=3'b111, go to FIN.
  - BUSY:
    - Send 0xFF bytes until a received byte equals 0xFF, then go to FIN.
    - Reaching BUSY_TIMEOUT bytes first sets status=3'b111.
  - FIN: CS=1, send 8 extra clocks with DI=1, then assert done for 1 cycle. err = (status != 3'b010). busy=0, return to IDLE.
- `start` arriving while busy is ignored. `start` in the same cycle that done pulses is also ignored.
- status holds its value until the next accepted start.
- Counters: byte index is 10-bit and compares against BLK_BYTES-1; timeout counters saturate at their limit.

Optional Feature:
- Macro: SD_CRC16_EN.
- Defined: CRC16-CCITT (poly 0x1021, init 0x0000) is computed over the data bytes bit-serially as each bit shifts out. The result is sent in the CRC state.
- Undefined: CRC bytes are sent as 0xFFFF. This is valid because SPI mode ignores CRC by default. The CRC logic is absent.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, GAP, TOKEN, DATA, CRC, RESP, BUSY, FIN);
  - constant TOKEN_START=8'hFE;
  - response codes RESP_OK=3'b010, RESP_CRC=3'b101, RESP_WERR=3'b110, RESP_TMO=3'b111.
- One sub-module: sd_crc16, a serial CRC16 with bit-in, enable and clear inputs.

Test Plan:
- Sector byte i = i[7:0], DO model returns 0xE5 then busy 0x00 ×3 then 0xFF → exactly 512+4 bytes of MOSI before RESP; done=1, err=0, status=3'b010.
- SD_CRC16_EN defined, sector all 0xFF → CRC bytes on DI are 0x7F, 0xA1.
- Response 0x0B → status=3'b101, err=1, CS high before done.
- DO held high throughout → done after 8 RESP bytes; status=3'b111, err=1.
- `start` pulsed during DATA → ignored, no second block. Reset driven low mid-DATA → CS=1, DI=1, SCLK=0 asynchronously, no done pulse.
- CLK_DIV=1 with the same stimulus as the first scenario → identical byte stream at SCLK = clk/2, with no inter-byte gaps in DATA.
